// File: rtl/sdram_wb_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller bridge and its helpers.
package sdram_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int GUARD_CYCLES = 1;
    localparam int SD_AW        = 25;

endpackage

// File: rtl/sdram_wb_watchdog.sv
// Cycle watchdog for SDRAM clients: counts enabled cycles and flags the TIMEOUT-th one.
module sdram_wb_watchdog #(
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic init_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] count;

    // expired is high during the enabled cycle that would make the count reach TIMEOUT
    assign expired = enable && (count == LAST);

    always_ff @(posedge clk or negedge init_n) begin
        // NOTE: sequential state is always written with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!init_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone 16-bit slave driving the SDRAM controller's edge-triggered rd/we/ready port.
// Define SDRAM_WB_POSTED_WRITE_EN to ack writes at accept and report their timeouts on the next cycle.
module sdram_wb_bridge
    import sdram_wb_pkg::*;
#(
    parameter int               AW      = 21,
    parameter logic [SD_AW-1:0] BASE    = '0,
    parameter int               TIMEOUT = 255,
    parameter int               TW      = 8
) (
    input  logic             clk,
    input  logic             init_n,
    input  logic             wb_cyc,
    input  logic             wb_stb,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_adr,
    input  logic [1:0]       wb_sel,
    input  logic [15:0]      wb_dat_i,
    output logic [15:0]      wb_dat_o,
    output logic             wb_ack,
    output logic             wb_err,
    output logic [SD_AW-1:0] sd_addr,
    output logic [15:0]      sd_din,
    output logic [1:0]       sd_wtbt,
    output logic             sd_we,
    output logic             sd_rd,
    input  logic [15:0]      sd_dout,
    input  logic             sd_ready
);

`ifdef SDRAM_WB_POSTED_WRITE_EN
    localparam bit POSTED_WRITE = 1'b1;
`else
    localparam bit POSTED_WRITE = 1'b0;
`endif

    state_t           state;
    logic [1:0]       guard_cnt;
    logic             is_write;
    logic             aborted;
    logic             err_pending;
    logic             wd_expired;
    logic [SD_AW-1:0] addr_sum;

    assign addr_sum = BASE + SD_AW'({wb_adr, 1'b0});

    sdram_wb_watchdog #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .init_n  (init_n),
        .clear   (state != WAIT),
        .enable  ((state == WAIT) && !sd_ready),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state       <= IDLE;
            guard_cnt   <= '0;
            is_write    <= 1'b0;
            aborted     <= 1'b0;
            err_pending <= 1'b0;
            wb_dat_o    <= '0;
            wb_ack      <= 1'b0;
            wb_err      <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            sd_wtbt     <= '0;
            sd_we       <= 1'b0;
            sd_rd       <= 1'b0;
        end else begin
            // ack/err default low so each can only ever be a single-cycle pulse
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (wb_cyc && wb_stb) begin
                        if (err_pending) begin
                            wb_err      <= 1'b1;
                            err_pending <= 1'b0;
                            state       <= GAP;
                        end else if (wb_we && (wb_sel == 2'b00)) begin
                            // empty-lane write never reaches the controller's 8-bit mode
                            wb_ack <= 1'b1;
                            state  <= GAP;
                        end else if (sd_ready) begin
                            sd_addr   <= {addr_sum[SD_AW-1:1], 1'b0};
                            sd_din    <= wb_dat_i;
                            sd_wtbt   <= wb_we ? wb_sel : 2'b11;
                            sd_we     <= wb_we;
                            sd_rd     <= !wb_we;
                            is_write  <= wb_we;
                            aborted   <= 1'b0;
                            guard_cnt <= '0;
                            wb_ack    <= POSTED_WRITE && wb_we;
                            state     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (!wb_cyc) aborted <= 1'b1;
                    if (guard_cnt == 2'(GUARD_CYCLES - 1)) begin
                        state <= WAIT;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (sd_ready || wd_expired) begin
                        sd_rd <= 1'b0;
                        sd_we <= 1'b0;
                        state <= GAP;
                        if (sd_ready) begin
                            if (!is_write) wb_dat_o <= sd_dout;
                            if (!(POSTED_WRITE && is_write)) wb_ack <= wb_cyc && !aborted;
                        end else if (POSTED_WRITE && is_write) begin
                            err_pending <= 1'b1;
                        end else begin
                            // a master that already left the bus must not see a stray err
                            wb_err <= wb_cyc && !aborted;
                        end
                    end else if (!wb_cyc) begin
                        aborted <= 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed self-checking bench for sdram_wb_bridge (BASE=0, TIMEOUT=16).
module tb_sdram_wb_bridge;
    import sdram_wb_pkg::*;

    logic        clk = 1'b0;
    logic        init_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [20:0] wb_adr;
    logic [1:0]  wb_sel;
    logic [15:0] wb_dat_i, wb_dat_o;
    logic        wb_ack, wb_err;
    logic [24:0] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_wtbt;
    logic        sd_we, sd_rd;
    logic [15:0] sd_dout;
    logic        sd_ready;

    int checks   = 0;
    int failures = 0;

    int rd_edges = 0, we_edges = 0;
    logic prev_rd = 1'b0, prev_we = 1'b0, prev_ack = 1'b0, prev_err = 1'b0;
    logic both_seen = 1'b0, ack_double = 1'b0, err_double = 1'b0;

    sdram_wb_bridge #(
        .AW      (21),
        .BASE    (25'h0),
        .TIMEOUT (16),
        .TW      (8)
    ) dut (
        .clk      (clk),
        .init_n   (init_n),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_sel   (wb_sel),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .sd_addr  (sd_addr),
        .sd_din   (sd_din),
        .sd_wtbt  (sd_wtbt),
        .sd_we    (sd_we),
        .sd_rd    (sd_rd),
        .sd_dout  (sd_dout),
        .sd_ready (sd_ready)
    );

    always #5 clk = ~clk;

    // Output monitor on the falling edge: request edges and ack/err pulse shape.
    always @(negedge clk) begin
        if (sd_rd && !prev_rd) rd_edges++;
        if (sd_we && !prev_we) we_edges++;
        if (wb_ack && wb_err) both_seen = 1'b1;
        if (wb_ack && prev_ack) ack_double = 1'b1;
        if (wb_err && prev_err) err_double = 1'b1;
        prev_rd  = sd_rd;
        prev_we  = sd_we;
        prev_ack = wb_ack;
        prev_err = wb_err;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [20:0] adr, input logic [1:0] sel,
                           input logic [15:0] dat);
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = we;
        wb_adr   = adr;
        wb_sel   = sel;
        wb_dat_i = dat;
    endtask

    task automatic release_bus();
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
    endtask

    // Read with sd_ready held high: ack must appear on the third edge counting the accept edge.
    task automatic read_hit(input string tag, input logic [20:0] adr, input logic [24:0] exp_addr,
                            input logic [15:0] data);
        sd_ready = 1'b1;
        sd_dout  = data;
        present(1'b0, adr, 2'b11, 16'h0);
        step();
        check({tag, "_rd_up"}, sd_rd, 1);
        check({tag, "_addr"}, sd_addr, exp_addr);
        wb_stb = 1'b0;
        step();
        check({tag, "_no_early_ack"}, wb_ack, 0);
        step();
        check({tag, "_ack"}, wb_ack, 1);
        check({tag, "_data"}, wb_dat_o, data);
        check({tag, "_rd_low"}, sd_rd, 0);
        release_bus();
        step();
        check({tag, "_ack_clear"}, wb_ack, 0);
    endtask

    initial begin
        int edges0;
        logic seen;

        init_n   = 1'b0;
        sd_dout  = '0;
        sd_ready = 1'b0;
        wb_adr   = '0;
        wb_sel   = '0;
        wb_dat_i = '0;
        release_bus();
        step();
        step();
        check("reset_outputs", {wb_dat_o, wb_ack, wb_err, sd_addr, sd_din, sd_wtbt, sd_we, sd_rd}, 0);
        #3 init_n = 1'b1;
        step();

        // 1: read miss returning 0xBEEF
        edges0   = rd_edges;
        sd_ready = 1'b1;
        sd_dout  = 16'hBEEF;
        present(1'b0, 21'h100, 2'b11, 16'h0);
        step();
        check("t1_addr", sd_addr, 25'h200);
        check("t1_rd_up", sd_rd, 1);
        check("t1_wtbt", sd_wtbt, 2'b11);
        sd_ready = 1'b0;
        wb_stb   = 1'b0;
        step();
        step();
        check("t1_no_ack_busy", wb_ack, 0);
        sd_ready = 1'b1;
        step();
        check("t1_ack", wb_ack, 1);
        check("t1_data", wb_dat_o, 16'hBEEF);
        check("t1_rd_low", sd_rd, 0);
        release_bus();
        step();
        check("t1_ack_once", wb_ack, 0);
        check("t1_rd_edges", rd_edges - edges0, 1);

        // 2 and 6: back-to-back hit reads of the same word
        edges0 = rd_edges;
        read_hit("t2a", 21'h101, 25'h202, 16'hA5A5);
        read_hit("t2b", 21'h101, 25'h202, 16'h5A5A);
        check("t2_rd_edges", rd_edges - edges0, 2);

        // 3: high-lane write, then empty-lane write
        edges0   = we_edges;
        sd_ready = 1'b1;
        present(1'b1, 21'h010, 2'b10, 16'h1234);
        step();
        check("t3_we_up", sd_we, 1);
        check("t3_wtbt", sd_wtbt, 2'b10);
        check("t3_din", sd_din, 16'h1234);
        check("t3_addr", sd_addr, 25'h20);
`ifdef SDRAM_WB_POSTED_WRITE_EN
        check("t3_posted_ack", wb_ack, 1);
`else
        check("t3_no_ack_at_accept", wb_ack, 0);
`endif
        sd_ready = 1'b0;
        wb_stb   = 1'b0;
        step();
        step();
        check("t3_no_ack_busy", wb_ack, 0);
        sd_ready = 1'b1;
        step();
`ifdef SDRAM_WB_POSTED_WRITE_EN
        check("t3_no_late_ack", wb_ack, 0);
`else
        check("t3_ack", wb_ack, 1);
`endif
        check("t3_we_low", sd_we, 0);
        release_bus();
        step();
        check("t3_we_edges", we_edges - edges0, 1);

        edges0 = we_edges;
        present(1'b1, 21'h011, 2'b00, 16'hFFFF);
        step();
        check("t3_sel0_ack", wb_ack, 1);
        check("t3_sel0_no_we", sd_we, 0);
        release_bus();
        step();
        check("t3_sel0_ack_clear", wb_ack, 0);
        check("t3_sel0_we_edges", we_edges - edges0, 0);

        // 4: sd_ready stuck low -> err after 16 WAIT cycles
        sd_ready = 1'b1;
        present(1'b0, 21'h020, 2'b11, 16'h0);
        step();
        sd_ready = 1'b0;
        wb_stb   = 1'b0;
        seen     = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            seen |= wb_err | wb_ack;
        end
        check("t4_no_early_err", seen, 0);
        check("t4_rd_held", sd_rd, 1);
        step();
        check("t4_err", wb_err, 1);
        check("t4_no_ack", wb_ack, 0);
        check("t4_rd_dropped", sd_rd, 0);
        release_bus();
        step();
        check("t4_err_clear", wb_err, 0);
        read_hit("t4_next", 21'h021, 25'h42, 16'h0F0F);

        // 5: cycle dropped in WAIT, then reset mid-WAIT
        sd_ready = 1'b1;
        present(1'b0, 21'h030, 2'b11, 16'h0);
        step();
        sd_ready = 1'b0;
        step();
        release_bus();
        step();
        sd_ready = 1'b1;
        step();
        check("t5_abort_no_ack", wb_ack, 0);
        check("t5_abort_rd_low", sd_rd, 0);
        step();
        check("t5_abort_no_ack_gap", wb_ack, 0);

        present(1'b0, 21'h040, 2'b11, 16'h0);
        step();
        sd_ready = 1'b0;
        wb_stb   = 1'b0;
        step();
        step();
        check("t5_rd_before_reset", sd_rd, 1);
        #2 init_n = 1'b0;
        #1;
        check("t5_reset_outputs", {wb_dat_o, wb_ack, wb_err, sd_addr, sd_din, sd_wtbt, sd_we, sd_rd}, 0);
        check("t5_reset_state", dut.state, IDLE);
        release_bus();
        step();
        check("t5_reset_no_ack", wb_ack, 0);
        #3 init_n = 1'b1;
        step();
        read_hit("t5_after_reset", 21'h050, 25'hA0, 16'hC3C3);

        check("ack_err_exclusive", both_seen, 0);
        check("ack_single_cycle", ack_double, 0);
        check("err_single_cycle", err_double, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
